// File: rtl/poolb_pkg.sv
// Shared types and elaboration-time geometry helpers for the 2x2 pooling sequencer.
package poolb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int bits_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ofm_size_f(input int ifm_size);
        return ifm_size / 2;
    endfunction

    function automatic int num_passes_f(input int depth, input int units);
        return (depth + units - 1) / units;
    endfunction

    function automatic int ifm_aw_f(input int ifm_size, input int depth, input int units);
        return bits_f(num_passes_f(depth, units) * ifm_size * ifm_size);
    endfunction

    function automatic int ofm_aw_f(input int ifm_size, input int depth, input int units);
        return bits_f(num_passes_f(depth, units) * ofm_size_f(ifm_size) * ofm_size_f(ifm_size));
    endfunction

endpackage

// File: rtl/poolb_addr_gen.sv
// Nested col/row/pass counters pointing at the next IFM read pair (even row on A, odd row on B).
module poolb_addr_gen
    import poolb_pkg::*;
#(
    parameter int  IFM_SIZE  = 7,
    parameter int  IFM_DEPTH = 16,
    parameter int  NUM_UNITS = 3,
    localparam int IFM_AW    = ifm_aw_f(IFM_SIZE, IFM_DEPTH, NUM_UNITS),
    localparam int PASS_W    = bits_f(num_passes_f(IFM_DEPTH, NUM_UNITS))
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_i,
    output logic [IFM_AW-1:0] ifm_addr_a_o,
    output logic [IFM_AW-1:0] ifm_addr_b_o,
    output logic              last_col_odd_o,
    output logic              last_read_o,
    output logic [PASS_W-1:0] pass_o
);

    localparam int OFM_SIZE   = ofm_size_f(IFM_SIZE);
    localparam int NUM_PASSES = num_passes_f(IFM_DEPTH, NUM_UNITS);
    localparam int COL_W      = bits_f(2 * OFM_SIZE);
    localparam int ROW_W      = bits_f(OFM_SIZE);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(2 * OFM_SIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(OFM_SIZE - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);
    localparam logic [IFM_AW-1:0] ROW_STEP  = IFM_AW'(2 * IFM_SIZE);
    localparam logic [IFM_AW-1:0] PASS_STEP = IFM_AW'(IFM_SIZE * IFM_SIZE);

    logic [COL_W-1:0]  col_q,   col_d;
    logic [ROW_W-1:0]  row_q,   row_d;
    logic [PASS_W-1:0] pass_q,  pass_d;
    // Running base offsets keep the address path free of multipliers.
    logic [IFM_AW-1:0] pbase_q, pbase_d;
    logic [IFM_AW-1:0] roff_q,  roff_d;

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        pass_d  = pass_q;
        pbase_d = pbase_q;
        roff_d  = roff_q;
        if (step_i) begin
            if (col_q != COL_LAST) begin
                col_d = col_q + COL_W'(1);
            end else begin
                col_d = '0;
                if (row_q != ROW_LAST) begin
                    row_d  = row_q + ROW_W'(1);
                    roff_d = roff_q + ROW_STEP;
                end else begin
                    row_d  = '0;
                    roff_d = '0;
                    if (pass_q != PASS_LAST) begin
                        pass_d  = pass_q + PASS_W'(1);
                        pbase_d = pbase_q + PASS_STEP;
                    end else begin
                        pass_d  = '0;
                        pbase_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            pass_q  <= '0;
            pbase_q <= '0;
            roff_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pass_q  <= pass_d;
            pbase_q <= pbase_d;
            roff_q  <= roff_d;
        end
    end

    assign ifm_addr_a_o   = pbase_q + roff_q + IFM_AW'(col_q);
    assign ifm_addr_b_o   = pbase_q + roff_q + IFM_AW'(col_q) + IFM_AW'(IFM_SIZE);
    assign last_col_odd_o = col_q[0];
    assign last_read_o    = (col_q == COL_LAST) && (row_q == ROW_LAST) && (pass_q == PASS_LAST);
    assign pass_o         = pass_q;

endmodule

// File: rtl/poolb_seq_u3.sv
// Sequencer for the 3-unit 2x2 pooling datapath: FSM, IFM read issue and the
// two-stage enable/OFM-write pipeline aligned to 1-cycle RAM read latency.
module poolb_seq_u3
    import poolb_pkg::*;
#(
    parameter int  IFM_SIZE    = 7,
    parameter int  IFM_DEPTH   = 16,
    parameter int  KERNAL_SIZE = 2,
    parameter int  NUM_UNITS   = 3,
    localparam int IFM_AW      = ifm_aw_f(IFM_SIZE, IFM_DEPTH, NUM_UNITS),
    localparam int OFM_AW      = ofm_aw_f(IFM_SIZE, IFM_DEPTH, NUM_UNITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 ifm_rd_en,
    output logic [IFM_AW-1:0]    ifm_addr_A,
    output logic [IFM_AW-1:0]    ifm_addr_B,
    output logic                 fifo_enable,
    output logic                 pool_enable,
    output logic                 ofm_wr_en,
    output logic [OFM_AW-1:0]    ofm_addr,
    output logic [NUM_UNITS-1:0] ofm_wr_mask
);

    localparam int PASS_W = bits_f(num_passes_f(IFM_DEPTH, NUM_UNITS));

    if (KERNAL_SIZE != 2) begin : g_kernel_check
        $error("poolb_seq_u3: only KERNAL_SIZE=2 is supported");
    end

    state_e state_q, state_d;
    logic   drain_q, drain_d;
    logic   issue;

    logic [IFM_AW-1:0]    gen_a, gen_b;
    logic                 gen_odd, gen_last;
    logic [PASS_W-1:0]    gen_pass;
    logic [NUM_UNITS-1:0] pass_mask;

    logic                 busy_q, done_q;
    logic                 rd_en_p0_q, rd_last_p0_q, odd_p0_q;
    logic [IFM_AW-1:0]    addr_a_p0_q, addr_b_p0_q;
    logic [NUM_UNITS-1:0] mask_p0_q, mask_p1_q, mask_p2_q;
    logic                 fifo_p1_q, pool_p1_q;
    logic                 wr_en_p2_q;
    logic [OFM_AW-1:0]    ofm_addr_p2_q, wr_cnt_q;

    poolb_addr_gen #(
        .IFM_SIZE  (IFM_SIZE),
        .IFM_DEPTH (IFM_DEPTH),
        .NUM_UNITS (NUM_UNITS)
    ) u_addr_gen (
        .clk            (clk),
        .reset          (reset),
        .step_i         (issue),
        .ifm_addr_a_o   (gen_a),
        .ifm_addr_b_o   (gen_b),
        .last_col_odd_o (gen_odd),
        .last_read_o    (gen_last),
        .pass_o         (gen_pass)
    );

    // A unit is only valid when its channel exists; only the final pass can be partial.
    always_comb begin
        pass_mask = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            pass_mask[u] = ((int'(gen_pass) * NUM_UNITS + u) < IFM_DEPTH);
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    issue   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rd_last_p0_q) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            drain_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_en_p0_q    <= 1'b0;
            rd_last_p0_q  <= 1'b0;
            odd_p0_q      <= 1'b0;
            addr_a_p0_q   <= '0;
            addr_b_p0_q   <= '0;
            mask_p0_q     <= '0;
            fifo_p1_q     <= 1'b0;
            pool_p1_q     <= 1'b0;
            mask_p1_q     <= '0;
            wr_en_p2_q    <= 1'b0;
            ofm_addr_p2_q <= '0;
            mask_p2_q     <= '0;
            wr_cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            busy_q  <= (state_d == RUN) || (state_d == DRAIN);
            done_q  <= (state_d == DONE);
            // p0: read issued, addresses presented to the RAMs
            rd_en_p0_q   <= issue;
            rd_last_p0_q <= issue & gen_last;
            odd_p0_q     <= issue & gen_odd;
            addr_a_p0_q  <= issue ? gen_a : '0;
            addr_b_p0_q  <= issue ? gen_b : '0;
            mask_p0_q    <= issue ? pass_mask : '0;
            // p1: RAM data valid, datapath captures/pools it
            fifo_p1_q <= rd_en_p0_q;
            pool_p1_q <= odd_p0_q;
            mask_p1_q <= odd_p0_q ? mask_p0_q : '0;
            // p2: pooled result valid, OFM write; writes are dense so a counter is the address
            wr_en_p2_q    <= pool_p1_q;
            ofm_addr_p2_q <= pool_p1_q ? wr_cnt_q : '0;
            mask_p2_q     <= pool_p1_q ? mask_p1_q : '0;
            if (state_q == IDLE) begin
                wr_cnt_q <= '0;
            end else if (pool_p1_q) begin
                wr_cnt_q <= wr_cnt_q + OFM_AW'(1);
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ifm_rd_en   = rd_en_p0_q;
    assign ifm_addr_A  = addr_a_p0_q;
    assign ifm_addr_B  = addr_b_p0_q;
    assign fifo_enable = fifo_p1_q;
    assign pool_enable = pool_p1_q;
    assign ofm_wr_en   = wr_en_p2_q;
    assign ofm_addr    = ofm_addr_p2_q;
    assign ofm_wr_mask = mask_p2_q;

endmodule

// File: tb/tb_poolb_seq_u3.sv
// Bench for poolb_seq_u3: two instances (7x7x16 and 4x4x3) checked every cycle
// against a schedule model derived from read index k = cycle - start_cycle - 1.
module tb_poolb_seq_u3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start0, start1;

    logic       busy0, done0, rd0, fifo0, pool0, wr0;
    logic [8:0] a0, b0;
    logic [5:0] oa0;
    logic [2:0] m0;

    logic       busy1, done1, rd1, fifo1, pool1, wr1;
    logic [3:0] a1, b1;
    logic [1:0] oa1;
    logic [2:0] m1;

    poolb_seq_u3 dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .ifm_rd_en(rd0), .ifm_addr_A(a0), .ifm_addr_B(b0), .fifo_enable(fifo0),
        .pool_enable(pool0), .ofm_wr_en(wr0), .ofm_addr(oa0), .ofm_wr_mask(m0)
    );

    poolb_seq_u3 #(.IFM_SIZE(4), .IFM_DEPTH(3)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .ifm_rd_en(rd1), .ifm_addr_A(a1), .ifm_addr_B(b1), .fifo_enable(fifo1),
        .pool_enable(pool1), .ofm_wr_en(wr1), .ofm_addr(oa1), .ofm_wr_mask(m1)
    );

    typedef struct {
        int busy, done, rd, a, b, fifo, pool, wr, oaddr, mask;
    } exp_t;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = -3;
    bit act0 = 0, act1 = 0;
    int s0 = 0, s1 = 0;
    localparam int R0 = 108;
    localparam int R1 = 8;
    localparam int LAST = 1800;

    // Expected outputs for read index k of a run on an SxS x D map, 3 units.
    function automatic exp_t model(input int S, input int D, input int k);
        exp_t e;
        int O, PR, R, p, r, col, j;
        e = '{default: 0};
        O = S / 2;
        PR = 2 * O * O;
        R = ((D + 2) / 3) * PR;
        if (k >= 0 && k < R + 2) e.busy = 1;
        if (k == R + 2) e.done = 1;
        if (k >= 0 && k < R) begin
            p = k / PR; r = (k % PR) / (2 * O); col = k % (2 * O);
            e.rd = 1;
            e.a = p * S * S + 2 * r * S + col;
            e.b = e.a + S;
        end
        j = k - 1;
        if (j >= 0 && j < R) begin
            e.fifo = 1;
            e.pool = (j % (2 * O)) % 2;
        end
        j = k - 2;
        if (j >= 0 && j < R && ((j % (2 * O)) % 2) == 1) begin
            p = j / PR; r = (j % PR) / (2 * O); col = j % (2 * O);
            e.wr = 1;
            e.oaddr = p * O * O + r * O + col / 2;
            for (int u = 0; u < 3; u++) if (p * 3 + u < D) e.mask |= (1 << u);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    endtask

    task automatic cmp(input string nm, input exp_t g, input exp_t e);
        bit ok;
        ok = (g.busy == e.busy) && (g.done == e.done) && (g.rd == e.rd) && (g.a == e.a) &&
             (g.b == e.b) && (g.fifo == e.fifo) && (g.pool == e.pool) && (g.wr == e.wr) &&
             (g.oaddr == e.oaddr) && (g.mask == e.mask);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s cyc=%0d got busy=%0d done=%0d rd=%0d A=%0d B=%0d fifo=%0d pool=%0d wr=%0d oaddr=%0d mask=%0d exp busy=%0d done=%0d rd=%0d A=%0d B=%0d fifo=%0d pool=%0d wr=%0d oaddr=%0d mask=%0d",
                      nm, cyc, g.busy, g.done, g.rd, g.a, g.b, g.fifo, g.pool, g.wr, g.oaddr, g.mask,
                      e.busy, e.done, e.rd, e.a, e.b, e.fifo, e.pool, e.wr, e.oaddr, e.mask);
    endtask

    function automatic bit idle(input bit act, input int s, input int R, input int c);
        return !act || (c - s - 1 > R + 2);
    endfunction

    int rd_cnt0 = 0, wr_cnt0 = 0, busy_cnt0 = 0, done_cnt0 = 0;
    int rd_cnt1 = 0, wr_cnt1 = 0;

    always @(negedge clk) begin
        exp_t g0, e0, g1, e1;
        if (cyc >= -2) begin
            g0 = '{busy0, done0, rd0, int'(a0), int'(b0), fifo0, pool0, wr0, int'(oa0), int'(m0)};
            g1 = '{busy1, done1, rd1, int'(a1), int'(b1), fifo1, pool1, wr1, int'(oa1), int'(m1)};
            e0 = model(7, 16, (act0 && !reset) ? cyc - s0 - 1 : -100);
            e1 = model(4, 3, (act1 && !reset) ? cyc - s1 - 1 : -100);
            cmp("dut0_cycle", g0, e0);
            cmp("dut1_cycle", g1, e1);

            if (cyc >= 0 && cyc < 116) begin
                rd_cnt0 += int'(rd0); wr_cnt0 += int'(wr0);
                busy_cnt0 += int'(busy0); done_cnt0 += int'(done0);
            end
            if (cyc >= 0 && cyc < 16) begin
                rd_cnt1 += int'(rd1); wr_cnt1 += int'(wr1);
            end

            if (cyc == -1) chk("reset_state", int'({busy0, done0, rd0, a0, b0, fifo0, pool0, wr0, oa0, m0}), 0);
            if (cyc == 1) begin chk("first_rd", rd0, 1); chk("first_A", a0, 0); chk("first_B", b0, 7); end
            if (cyc == 2) begin chk("first_fifo", fifo0, 1); chk("first_pool_even", pool0, 0); end
            if (cyc == 3) chk("first_pool", pool0, 1);
            if (cyc == 4) begin chk("first_wr", wr0, 1); chk("first_oaddr", oa0, 0); chk("first_mask", m0, 7); end
            if (cyc == 7) begin chk("row1_A", a0, 14); chk("row1_B", b0, 21); end
            if (cyc == 19) begin chk("pass1_A", a0, 49); chk("pass1_B", b0, 56); end
            if (cyc == 22) begin chk("pass1_wr", wr0, 1); chk("pass1_oaddr", oa0, 9); end
            if (cyc == 110) begin
                chk("last_wr", wr0, 1); chk("last_oaddr", oa0, 53);
                chk("last_mask", m0, 1); chk("last_busy", busy0, 1);
            end
            if (cyc == 111) begin chk("done_pulse", done0, 1); chk("done_busy", busy0, 0); end
            if (cyc == 112) chk("after_done_idle", int'({busy0, done0, rd0, fifo0, pool0, wr0}), 0);
            if (cyc == 116) begin
                chk("run_reads", rd_cnt0, 108); chk("run_writes", wr_cnt0, 54);
                chk("run_busy_cycles", busy_cnt0, 110); chk("run_done_cycles", done_cnt0, 1);
            end
            if (cyc == 150) chk("reset_mid_run", int'({busy0, rd0, a0, b0, fifo0, pool0, wr0, oa0, m0}), 0);
            if (cyc == 161) begin chk("restart_rd", rd0, 1); chk("restart_A", a0, 0); chk("restart_B", b0, 7); end
            if (cyc == 5) begin chk("small_wr0", wr1, 1); chk("small_oaddr0", oa1, 0); chk("small_mask", m1, 7); end
            if (cyc == 6) begin chk("small_row1_A", a1, 8); chk("small_row1_B", b1, 12); end
            if (cyc == 11) begin chk("small_wr3", wr1, 1); chk("small_oaddr3", oa1, 3); end
            if (cyc == 12) chk("small_done", done1, 1);
            if (cyc == 16) begin chk("small_reads", rd_cnt1, 8); chk("small_writes", wr_cnt1, 4); end
        end
    end

    initial begin
        reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int c = -2; c <= LAST; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            reset = (c < -1) || (c == 150) || (c >= 280 && $urandom_range(0, 299) == 0);
            start0 = (c == 0) || (c == 20) || (c == 111) || (c == 130) || (c == 160) ||
                     (c >= 280 && $urandom_range(0, 15) == 0);
            start1 = (c == 1) || (c >= 280 && $urandom_range(0, 11) == 0);
            if (reset) begin
                act0 = 0;
                act1 = 0;
            end else begin
                if (start0 && idle(act0, s0, R0, c)) begin act0 = 1; s0 = c; end
                if (start1 && idle(act1, s1, R1, c)) begin act1 = 1; s1 = c; end
            end
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
